// File: rtl/spi_cmd_master_if.sv
// Command-side and serial-link signals of the 16-bit SPI command master.
// The master modport is the DUT's view; the slave modport is the environment's view.
interface spi_cmd_master_if;
    logic        wrt_cmd;
    logic [15:0] command;
    logic        MISO;
    logic        SCLK;
    logic        SS_n;
    logic        MOSI;
    logic        done;
    logic [15:0] resp;

    modport master (
        input  wrt_cmd, command, MISO,
        output SCLK, SS_n, MOSI, done, resp
    );

    modport slave (
        output wrt_cmd, command, MISO,
        input  SCLK, SS_n, MOSI, done, resp
    );
endinterface

// File: rtl/spi_cmd_master.sv
// 16-bit full-duplex SPI master, MSB first, SCLK idles high.
// One wrt_cmd accept runs one transaction; done and resp hold until the next accept.
module spi_cmd_master #(
    parameter int SCLK_DIV = 32
) (
    input  logic             clk,
    input  logic             rst,
    spi_cmd_master_if.master bus
);
    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(SCLK_DIV - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] FRONT     = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;
    localparam logic [1:0] DONE_EDGE = 2'd3;

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [3:0]    bit_q,    bit_d;
    logic          sclk_q,   sclk_d;
    logic          ss_n_q,   ss_n_d;
    logic          done_q,   done_d;
    logic          sample_q, sample_d;
    logic [15:0]   shft_q,   shft_d;
    logic [15:0]   resp_q,   resp_d;

    always_comb begin
        // NOTE: every next-state signal starts from its held value so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        ss_n_d   = ss_n_q;
        done_d   = done_q;
        sample_d = sample_q;
        shft_d   = shft_q;
        resp_d   = resp_q;

        case (state_q)
            IDLE: begin
                if (bus.wrt_cmd) begin
                    state_d = FRONT;
                    ss_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    shft_d  = bus.command;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            FRONT: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                // cnt runs over one bit period: low half first, then high half.
                if (cnt_q == HALF_LAST) begin
                    sclk_d   = 1'b1;
                    sample_d = bus.MISO;
                    if (bit_q == 4'd15) begin
                        state_d = DONE_EDGE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == FULL_LAST) begin
                    sclk_d = 1'b0;
                    shft_d = {shft_q[14:0], sample_q};
                    bit_d  = bit_q + 4'd1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE_EDGE: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = IDLE;
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                    shft_d  = {shft_q[14:0], sample_q};
                    resp_d  = {shft_q[14:0], sample_q};
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b1;
            ss_n_q   <= 1'b1;
            done_q   <= 1'b0;
            sample_q <= 1'b0;
            shft_q   <= '0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            ss_n_q   <= ss_n_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            shft_q   <= shft_d;
            resp_q   <= resp_d;
        end
    end

    assign bus.SCLK = sclk_q;
    assign bus.SS_n = ss_n_q;
    assign bus.MOSI = shft_q[15];
    assign bus.done = done_q;
    assign bus.resp = resp_q;
endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: vector table, random transactions against a
// transaction-level model, and hand-written sequences for ignore, reset and back-to-back.
module tb_spi_cmd_master;
    localparam int SCLK_DIV = 32;
    localparam int MAX_WAIT = 1500;

    typedef enum logic [1:0] {M_LOOP, M_ONES, M_WORD} mode_e;

    typedef struct {
        mode_e       mode;
        logic [15:0] cmd;
        logic [15:0] word;
        logic [15:0] exp_resp;
        logic [15:0] exp_rx;
    } vec_t;

    logic clk;
    logic rst;
    spi_cmd_master_if bus ();

    spi_cmd_master #(.SCLK_DIV(SCLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Slave model: shifts its word out on SCLK falls, samples MOSI on SCLK rises.
    mode_e       mode    = M_LOOP;
    logic [15:0] slv_word = '0;
    logic [15:0] slv_tx   = '0;
    logic [15:0] slv_rx   = '0;
    logic        slv_out  = 1'b0;
    int          rises = 0;
    int          falls = 0;
    int          stray = 0;
    logic        first_done;

    assign bus.MISO = (mode == M_LOOP) ? bus.MOSI :
                      (mode == M_ONES) ? 1'b1 : slv_out;

    always @(negedge bus.SS_n) begin
        slv_tx = slv_word;
        slv_rx = '0;
        rises  = 0;
        falls  = 0;
    end

    always @(negedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            slv_out = slv_tx[15];
            slv_tx  = {slv_tx[14:0], 1'b0};
            falls++;
        end
    end

    always @(posedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            slv_rx = {slv_rx[14:0], bus.MOSI};
            rises++;
        end
    end

    always @(bus.SCLK) begin
        if (bus.SS_n === 1'b1) stray++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Transaction-level reference: latency from the half-period count, response by slave behaviour.
    function automatic int model_latency();
        return 1 + 33 * (SCLK_DIV / 2);
    endfunction

    function automatic logic [15:0] model_resp(input mode_e m, input logic [15:0] cmd,
                                               input logic [15:0] word);
        case (m)
            M_LOOP:  return cmd;
            M_ONES:  return 16'hFFFF;
            default: return word;
        endcase
    endfunction

    // Accept cmd, optionally poke wrt_cmd=1/command=FFFF at poke_cycle; lat = first cycle done is seen.
    task automatic do_txn(input logic [15:0] cmd, input int poke_cycle, output int lat);
        stray = 0;
        @(posedge clk); #1;
        bus.wrt_cmd = 1'b1;
        bus.command = cmd;
        @(posedge clk); #1;
        bus.wrt_cmd = 1'b0;
        bus.command = 16'($urandom);
        lat = -1;
        for (int c = 1; c <= MAX_WAIT && lat < 0; c++) begin
            @(negedge clk);
            if (c == poke_cycle) begin
                bus.wrt_cmd = 1'b1;
                bus.command = 16'hFFFF;
            end else if (c == poke_cycle + 1) begin
                bus.wrt_cmd = 1'b0;
            end
            if (c == 1) first_done = bus.done;
            if (bus.done === 1'b1) lat = c;
        end
    endtask

    vec_t vecs[$];

    function automatic void add_vec(input mode_e m, input logic [15:0] cmd, input logic [15:0] word,
                                    input logic [15:0] er, input logic [15:0] ex);
        vec_t v;
        v.mode = m; v.cmd = cmd; v.word = word; v.exp_resp = er; v.exp_rx = ex;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          bad;
        logic        prev_ss;
        logic [15:0] cmd_r, word_r;

        add_vec(M_LOOP, 16'hA5C3, 16'h0000, 16'hA5C3, 16'hA5C3);
        add_vec(M_ONES, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
        add_vec(M_WORD, 16'hC00F, 16'h1234, 16'h1234, 16'hC00F);
        add_vec(M_WORD, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF);
        add_vec(M_LOOP, 16'h8001, 16'h0000, 16'h8001, 16'h8001);
        add_vec(M_WORD, 16'h0001, 16'h8000, 16'h8000, 16'h0001);
        for (int i = 0; i < 8; i++) begin
            mode_e m;
            m      = (i % 2 == 0) ? M_WORD : M_LOOP;
            cmd_r  = 16'($urandom);
            word_r = 16'($urandom);
            add_vec(m, cmd_r, word_r, model_resp(m, cmd_r, word_r), cmd_r);
        end

        bus.wrt_cmd = 1'b0;
        bus.command = 16'h0000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(bus.SS_n), 32'd1);
        check("rst_sclk", 32'(bus.SCLK), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_resp", 32'(bus.resp), 32'd0);
        check("rst_mosi", 32'(bus.MOSI), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            mode     = vecs[i].mode;
            slv_word = vecs[i].word;
            do_txn(vecs[i].cmd, -1, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(model_latency()));
            check($sformatf("v%0d_resp", i), 32'(bus.resp), 32'(vecs[i].exp_resp));
            check($sformatf("v%0d_slave_rx", i), 32'(slv_rx), 32'(vecs[i].exp_rx));
            check($sformatf("v%0d_rises", i), 32'(rises), 32'd16);
            check($sformatf("v%0d_falls", i), 32'(falls), 32'd16);
            check($sformatf("v%0d_stray_edges", i), 32'(stray), 32'd0);
            check($sformatf("v%0d_done_cleared", i), 32'(first_done), 32'd0);
        end

        // wrt_cmd during a transaction is ignored; done/resp then hold in IDLE.
        mode = M_LOOP;
        do_txn(16'h3C5A, 100, lat);
        check("poke_latency", 32'(lat), 32'(model_latency()));
        check("poke_resp", 32'(bus.resp), 32'h3C5A);
        check("poke_slave_rx", 32'(slv_rx), 32'h3C5A);
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b1 || bus.resp !== 16'h3C5A || bus.SS_n !== 1'b1) bad++;
        end
        check("idle_hold_bad_cycles", 32'(bad), 32'd0);

        // Back-to-back with wrt_cmd held high.
        mode = M_LOOP;
        @(posedge clk); #1;
        bus.wrt_cmd = 1'b1;
        bus.command = 16'h0001;
        @(posedge clk); #1;
        lat = -1;
        prev_ss = 1'b1;
        for (int c = 1; c <= MAX_WAIT && lat < 0; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) lat = c;
            else prev_ss = bus.SS_n;
        end
        check("b2b1_latency", 32'(lat), 32'(model_latency()));
        check("b2b1_resp", 32'(bus.resp), 32'h0001);
        check("b2b1_ss_before_done", 32'(prev_ss), 32'd0);
        check("b2b1_ss_at_done", 32'(bus.SS_n), 32'd1);
        bus.command = 16'h0002;
        @(negedge clk);
        check("b2b_gap_ss_low_again", 32'(bus.SS_n), 32'd0);
        check("b2b_gap_done_cleared", 32'(bus.done), 32'd0);
        bus.wrt_cmd = 1'b0;
        lat = -1;
        for (int c = 2; c <= MAX_WAIT && lat < 0; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) lat = c;
        end
        check("b2b2_latency", 32'(lat), 32'(model_latency()));
        check("b2b2_resp", 32'(bus.resp), 32'h0002);

        // Reset at cycle 200 of a transaction, then a clean transaction.
        mode = M_LOOP;
        @(posedge clk); #1;
        bus.wrt_cmd = 1'b1;
        bus.command = 16'h0F0F;
        @(posedge clk); #1;
        bus.wrt_cmd = 1'b0;
        for (int c = 1; c <= 200; c++) @(negedge clk);
        check("midrst_pre_ss", 32'(bus.SS_n), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_ss_n", 32'(bus.SS_n), 32'd1);
        check("midrst_sclk", 32'(bus.SCLK), 32'd1);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_resp", 32'(bus.resp), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_txn(16'h5AA5, -1, lat);
        check("postrst_latency", 32'(lat), 32'(model_latency()));
        check("postrst_resp", 32'(bus.resp), 32'h5AA5);
        check("postrst_rises", 32'(rises), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
